debug_sel_ctrl: RTL and testbench
=================================

Name: debug_sel_ctrl

Overview:
- Input-side companion to the debug display path: turns raw board push-buttons and a switch into the `sel[2:0]` / `high` controls that choose which 32-bit probe word and which half is shown on the 7-segment display.
- Synchronizes and debounces the buttons, then runs a manual/auto-scan state machine.
- Emits a one-cycle `changed` strobe whenever the displayed selection moves.

Parameters:
- DB_COUNT, 500000: consecutive stable synchronized cycles before a button level is accepted (10 ms at 50 MHz); must be ≥ 1.
- SCAN_COUNT, 50000000: cycles per auto-scan step (1 s at 50 MHz); must be ≥ 1.
- CNT_W, 26: width of the debounce and scan counters; must hold max(DB_COUNT, SCAN_COUNT).

Ports:
- cclk  in  1  system clock; all state on rising edge
- clr  in  1  reset, asynchronous assert, active-low (0 = reset)
- btn_next  in  1  raw push-button, active-high, asynchronous to cclk
- btn_prev  in  1  raw push-button, active-high, asynchronous
- btn_half  in  1  raw push-button, active-high, asynchronous
- sw_auto  in  1  raw slide switch, 1 = auto-scan mode, asynchronous
- sel  out  3  selected probe index
- high  out  1  1 = upper 16 bits shown, 0 = lower
- changed  out  1  one-cycle pulse in the cycle after {sel,high} updates
- auto_on  out  1  1 while FSM is in AUTO

Behaviour:
- Reset (clr = 0, async): sel = 0, high = 0, changed = 0, auto_on = 0, state MANUAL.
  - Reset also clears all synchronizer flops, debounced levels, debounce counters and the scan counter.
  - Reset release is not required to be synchronous inside this block.
- Synchronizer: each raw input passes through 2 flops before any use.
- Debounce, applied per input including sw_auto:
  - Counter resets to 0 whenever the synchronized level differs from its value in the previous cycle.
  - Otherwise the counter increments, saturating.
  - When the counter reaches DB_COUNT, the debounced level takes the synchronized value.
- Press detection: a press pulse is the 0→1 transition of a button's debounced level, one cycle wide; releases generate nothing.
- Latency: raw rise → sync 2 cycles → stable DB_COUNT cycles → debounced updates → press pulse → sel/high update on the next edge → changed high the following cycle.
- Glitches: any glitch shorter than DB_COUNT cycles produces no pulse.
- FSM state MANUAL:
  - next pulse: sel ← sel + 1 mod 8 (7 → 0).
  - prev pulse: sel ← sel − 1 mod 8 (0 → 7).
  - next and prev in the same cycle: sel unchanged, no changed pulse.
  - half pulse: high ← ~high. It may coincide with a next or prev pulse; both apply in the same cycle.
  - Debounced sw_auto = 1 → AUTO; the scan counter is cleared on entry.
- FSM state AUTO:
  - All button pulses are ignored.
  - The scan counter counts 0 … SCAN_COUNT−1.
  - At terminal count, {sel,high} is incremented as a 4-bit value (0L, 0H, 1L, 1H, …, 7H, 0L) and the counter wraps to 0.
  - Debounced sw_auto = 0 → MANUAL; sel and high hold their current values.
  - If terminal count coincides with the exit, the step still occurs.
- changed: asserted for exactly one cycle after any cycle in which {sel,high} took a different value; never asserted for no-op events.
- auto_on: registered, equals (state == AUTO).
- Reset mid-operation: all state returns to reset values immediately.
  - A button still held at release must stay stable DB_COUNT cycles after sync before being accepted.
  - Because the debounced level resets to 0, a held button then yields exactly one press.

Decomposition:
- Shared package holds:
  - State encoding constants MANUAL = 0, AUTO = 1.
  - SEL_W = 3 and default timing constants, reused by the display-side mux.
- One sub-module, `btn_debounce`: synchronizer plus debounce counter, with debounced level and rise-pulse outputs.
  - Parameterised by DB_COUNT and CNT_W.
  - Instantiated 4 times.

Test Plan (benches override DB_COUNT = 4, SCAN_COUNT = 10):
- Reset: clr = 0 with buttons toggling → sel = 0, high = 0, changed = 0, auto_on = 0. Release, hold btn_next = 1 → exactly one increment to sel = 1 after 2 + 4 + 1 cycles, changed pulses once.
- Bounce: btn_next toggling with 3-cycle runs for 40 cycles, then released → sel unchanged, changed never asserted.
- Wrap and simultaneity:
  - 7 clean next presses, then one more → sel = 7, then 0.
  - A prev press at sel = 0 → sel = 7.
  - next and prev rising in the same cycle → no change, no changed pulse.
- Half: btn_half press at sel = 3 → high = 1, sel stays 3. Second press → high = 0.
- Auto: sw_auto = 1 from sel = 6, high = 1 → auto_on after debounce. After 10 cycles {sel,high} = 7L, after 20 cycles 7H, after 30 cycles 0L. btn_next presses during AUTO are ignored.
- Exit/reset: sw_auto = 0 → MANUAL holds current sel/high and buttons work again. Assert clr mid-scan → immediate return to all reset values.

Source files
------------

// File: rtl/debug_sel_ctrl_pkg.sv
// Shared constants for the debug display selection path: state encoding,
// probe-select width and default board timing.
package debug_sel_ctrl_pkg;

  localparam int SEL_W          = 3;
  localparam int DB_COUNT_DEF   = 500000;    // 10 ms at 50 MHz
  localparam int SCAN_COUNT_DEF = 50000000;  // 1 s at 50 MHz
  localparam int CNT_W_DEF      = 26;

  localparam int NUM_IN   = 4;
  localparam int IDX_NEXT = 0;
  localparam int IDX_PREV = 1;
  localparam int IDX_HALF = 2;
  localparam int IDX_AUTO = 3;

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } state_t;

endpackage

// File: rtl/debug_sel_ctrl_btn_debounce.sv
// Two-flop synchronizer plus stability counter for one raw board input;
// provides the debounced level and a one-cycle pulse on its rising edge.
module btn_debounce #(
  parameter int DB_COUNT = 500000,
  parameter int CNT_W    = 26
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DB_COUNT);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_COUNT - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_rise;
  logic [CNT_W-1:0] r_cnt;
  logic             w_stable;

  // r_sync1 is the value r_sync2 takes next, so comparing them restarts the
  // count on the same edge the synchronized level changes.
  assign w_stable = (r_sync1 == r_sync2) && (r_cnt >= DB_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync1 != r_sync2) begin
        r_cnt <= '0;
      end else if (r_cnt != DB_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_stable) begin
        r_level <= r_sync2;
      end
      r_rise <= w_stable && r_sync2 && !r_level;
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule

// File: rtl/debug_sel_ctrl.sv
// Turns board buttons and the auto switch into the probe select / half
// controls for the 7-segment debug display, with manual and auto-scan modes.
module debug_sel_ctrl
  import debug_sel_ctrl_pkg::*;
#(
  parameter int DB_COUNT   = DB_COUNT_DEF,
  parameter int SCAN_COUNT = SCAN_COUNT_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             cclk,
  input  logic             clr,
  input  logic             btn_next,
  input  logic             btn_prev,
  input  logic             btn_half,
  input  logic             sw_auto,
  output logic [SEL_W-1:0] sel,
  output logic             high,
  output logic             changed,
  output logic             auto_on
);

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_COUNT - 1);

  logic [NUM_IN-1:0] w_raw;
  logic [NUM_IN-1:0] w_lvl;
  logic [NUM_IN-1:0] w_rise;
  logic              w_unused;

  assign w_raw    = {sw_auto, btn_half, btn_prev, btn_next};
  assign w_unused = ^{w_lvl[IDX_HALF:IDX_NEXT], w_rise[IDX_AUTO]};

  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_db
      btn_debounce #(
        .DB_COUNT (DB_COUNT),
        .CNT_W    (CNT_W)
      ) u_db (
        .i_clk   (cclk),
        .i_rst_n (clr),
        .i_raw   (w_raw[gi]),
        .o_level (w_lvl[gi]),
        .o_rise  (w_rise[gi])
      );
    end
  endgenerate

  state_t           r_state;
  logic [SEL_W-1:0] r_sel;
  logic             r_high;
  logic [SEL_W:0]   r_prev_val;
  logic             r_changed;
  logic             r_auto_on;
  logic [CNT_W-1:0] r_scan_cnt;

  logic [SEL_W-1:0] w_man_sel;
  logic             w_man_high;
  logic [SEL_W:0]   w_auto_val;
  logic             w_scan_tc;

  always_comb begin
    w_man_sel  = r_sel;
    w_man_high = r_high;
    if (w_rise[IDX_NEXT] && !w_rise[IDX_PREV]) begin
      w_man_sel = r_sel + 1'b1;
    end else if (w_rise[IDX_PREV] && !w_rise[IDX_NEXT]) begin
      w_man_sel = r_sel - 1'b1;
    end
    if (w_rise[IDX_HALF]) begin
      w_man_high = ~r_high;
    end
  end

  assign w_auto_val = {r_sel, r_high} + 1'b1;
  assign w_scan_tc  = (r_scan_cnt == SCAN_LAST);

  // changed compares against last cycle's selection, so it trails the update
  // by one cycle and stays low for events that leave {sel,high} untouched.
  always_ff @(posedge cclk or negedge clr) begin
    if (!clr) begin
      r_state    <= MANUAL;
      r_sel      <= '0;
      r_high     <= 1'b0;
      r_prev_val <= '0;
      r_changed  <= 1'b0;
      r_auto_on  <= 1'b0;
      r_scan_cnt <= '0;
    end else begin
      r_prev_val <= {r_sel, r_high};
      r_changed  <= ({r_sel, r_high} != r_prev_val);
      case (r_state)
        MANUAL: begin
          r_sel  <= w_man_sel;
          r_high <= w_man_high;
          if (w_lvl[IDX_AUTO]) begin
            r_state    <= AUTO;
            r_auto_on  <= 1'b1;
            r_scan_cnt <= '0;
          end
        end
        AUTO: begin
          if (w_scan_tc) begin
            r_scan_cnt      <= '0;
            {r_sel, r_high} <= w_auto_val;
          end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
          end
          if (!w_lvl[IDX_AUTO]) begin
            r_state   <= MANUAL;
            r_auto_on <= 1'b0;
          end
        end
        default: begin
          r_state   <= MANUAL;
          r_auto_on <= 1'b0;
        end
      endcase
    end
  end

  assign sel     = r_sel;
  assign high    = r_high;
  assign changed = r_changed;
  assign auto_on = r_auto_on;

endmodule

// File: tb/tb_debug_sel_ctrl.sv
// Directed bench for debug_sel_ctrl with short debounce and scan periods:
// a press table for manual mode plus hand-written reset, bounce and auto runs.
module tb_debug_sel_ctrl;

  logic       cclk;
  logic       clr;
  logic       btn_next;
  logic       btn_prev;
  logic       btn_half;
  logic       sw_auto;
  logic [2:0] sel;
  logic       high;
  logic       changed;
  logic       auto_on;

  debug_sel_ctrl #(
    .DB_COUNT   (4),
    .SCAN_COUNT (10),
    .CNT_W      (26)
  ) dut (
    .cclk     (cclk),
    .clr      (clr),
    .btn_next (btn_next),
    .btn_prev (btn_prev),
    .btn_half (btn_half),
    .sw_auto  (sw_auto),
    .sel      (sel),
    .high     (high),
    .changed  (changed),
    .auto_on  (auto_on)
  );

  initial cclk = 1'b0;
  always #5 cclk = ~cclk;

  typedef struct {
    logic       nxt;
    logic       prv;
    logic       hlf;
    logic [2:0] sel;
    logic       high;
    int         chg;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   pulses;
  int   n;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One press of the given buttons: hold 10 cycles, release 10 cycles,
  // counting changed pulses over the whole window.
  task automatic press(input logic n_i, input logic p_i, input logic h_i, output int cnt);
    cnt = 0;
    btn_next = n_i;
    btn_prev = p_i;
    btn_half = h_i;
    repeat (10) begin
      @(negedge cclk);
      if (changed) cnt++;
    end
    btn_next = 1'b0;
    btn_prev = 1'b0;
    btn_half = 1'b0;
    repeat (10) begin
      @(negedge cclk);
      if (changed) cnt++;
    end
  endtask

  task automatic wait_auto(input logic want, input string name, inout int cnt);
    int k;
    k = 0;
    while (auto_on !== want && k < 40) begin
      @(negedge cclk);
      if (changed) cnt++;
      k++;
    end
    check(name, int'(auto_on), int'(want));
  endtask

  initial begin
    vecs.push_back('{1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 3'd5, 1'b0, 1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 3'd6, 1'b0, 1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 3'd7, 1'b0, 1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 3'd7, 1'b0, 1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 3'd4, 1'b0, 1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 3'd5, 1'b0, 1});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 3'd6, 1'b1, 1});

    clr      = 1'b0;
    btn_next = 1'b0;
    btn_prev = 1'b0;
    btn_half = 1'b0;
    sw_auto  = 1'b0;

    // Reset held while buttons toggle
    for (int i = 0; i < 12; i++) begin
      @(negedge cclk);
      btn_next = i[0];
      btn_prev = ~i[0];
      btn_half = i[1];
    end
    check("rst_sel", int'(sel), 0);
    check("rst_high", int'(high), 0);
    check("rst_changed", int'(changed), 0);
    check("rst_auto_on", int'(auto_on), 0);

    @(negedge cclk);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    btn_half = 1'b0;
    clr      = 1'b1;
    repeat (4) @(negedge cclk);

    // Held press: 2 sync + 4 stable + 1 update cycles, changed one cycle later
    btn_next = 1'b1;
    repeat (6) @(negedge cclk);
    check("lat_sel_before", int'(sel), 0);
    @(negedge cclk);
    check("lat_sel", int'(sel), 1);
    check("lat_chg_early", int'(changed), 0);
    @(negedge cclk);
    check("lat_chg", int'(changed), 1);
    pulses = 0;
    repeat (20) begin
      @(negedge cclk);
      if (changed) pulses++;
    end
    check("hold_extra_chg", pulses, 0);
    check("hold_sel", int'(sel), 1);
    btn_next = 1'b0;
    repeat (10) @(negedge cclk);

    // Bounce: 3-cycle runs never reach the 4-cycle stability window
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      btn_next = ((i / 3) % 2) == 0;
      @(negedge cclk);
      if (changed) pulses++;
    end
    btn_next = 1'b0;
    repeat (10) begin
      @(negedge cclk);
      if (changed) pulses++;
    end
    check("bounce_chg", pulses, 0);
    check("bounce_sel", int'(sel), 1);

    foreach (vecs[i]) begin
      press(vecs[i].nxt, vecs[i].prv, vecs[i].hlf, pulses);
      $display("vec %0d n=%0b p=%0b h=%0b -> sel=%0d high=%0b chg=%0d",
               i, vecs[i].nxt, vecs[i].prv, vecs[i].hlf, sel, high, pulses);
      check($sformatf("vec%0d_sel", i), int'(sel), int'(vecs[i].sel));
      check($sformatf("vec%0d_high", i), int'(high), int'(vecs[i].high));
      check($sformatf("vec%0d_chg", i), pulses, vecs[i].chg);
    end

    // Auto scan from 6H: steps every 10 cycles, button presses ignored
    pulses  = 0;
    sw_auto = 1'b1;
    wait_auto(1'b1, "auto_enter", pulses);
    check("auto_enter_val", int'({sel, high}), 13);
    pulses = 0;
    repeat (9) begin
      @(negedge cclk);
      if (changed) pulses++;
    end
    check("auto_pre_step", int'({sel, high}), 13);
    @(negedge cclk);
    if (changed) pulses++;
    check("auto_step1_7L", int'({sel, high}), 14);
    btn_next = 1'b1;
    repeat (10) begin
      @(negedge cclk);
      if (changed) pulses++;
    end
    check("auto_step2_7H", int'({sel, high}), 15);
    repeat (10) begin
      @(negedge cclk);
      if (changed) pulses++;
    end
    check("auto_step3_0L", int'({sel, high}), 0);
    btn_next = 1'b0;
    sw_auto  = 1'b0;
    wait_auto(1'b0, "auto_exit", pulses);
    check("exit_hold_val", int'({sel, high}), 0);
    check("auto_chg_count", pulses, 3);

    press(1'b1, 1'b0, 1'b0, pulses);
    check("manual_again_sel", int'(sel), 1);
    check("manual_again_chg", pulses, 1);

    // Reset mid-scan, with btn_prev held across the release
    pulses  = 0;
    sw_auto = 1'b1;
    wait_auto(1'b1, "auto_reenter", pulses);
    repeat (15) @(negedge cclk);
    check("midscan_val", int'({sel, high}), 3);
    btn_prev = 1'b1;
    #2;
    clr = 1'b0;
    #1;
    check("rst_mid_sel", int'(sel), 0);
    check("rst_mid_high", int'(high), 0);
    check("rst_mid_auto_on", int'(auto_on), 0);
    check("rst_mid_changed", int'(changed), 0);
    sw_auto = 1'b0;
    repeat (3) @(negedge cclk);
    clr    = 1'b1;
    pulses = 0;
    repeat (30) begin
      @(negedge cclk);
      if (changed) pulses++;
    end
    check("held_after_rst_sel", int'(sel), 7);
    check("held_after_rst_chg", pulses, 1);
    check("held_after_rst_auto", int'(auto_on), 0);
    btn_prev = 1'b0;
    repeat (10) @(negedge cclk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
